axi_slave_write_burst: RTL and testbench

AXI_SLAVE_WRITE_BURST -- requirements
Module: axi_slave_write_burst

---
 rtl/axi_slave_write_burst.sv | 168 ++++++++++++++++
 tb/tb_axi_slave_write_burst.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_write_burst.sv
// AXI write-burst slave: accepts one AW burst at a time, streams W beats to a
// simple byte-enabled memory port and returns a single B response per burst.
module axi_slave_write_burst #(
  parameter int DATA_BITS = 32,
  parameter int ID_BITS   = 8,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [ID_BITS-1:0]     AWID,
  input  logic [ADDR_BITS-1:0]   AWADDR,
  input  logic [LEN_BITS-1:0]    AWLEN,
  input  logic [2:0]             AWSIZE,
  input  logic [1:0]             AWBURST,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [DATA_BITS-1:0]   WDATA,
  input  logic [DATA_BITS/8-1:0] WSTRB,
  input  logic                   WLAST,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic [ID_BITS-1:0]     BID,
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY,
  input  logic                   mem_ready,
  output logic [ADDR_BITS-1:0]   mem_addr,
  output logic [DATA_BITS/8-1:0] mem_wen_n,
  output logic [DATA_BITS-1:0]   mem_wdata,
  output logic                   finish
);

  // state | meaning
  // IDLE  | waiting for an AW handshake
  // DATA  | accepting W beats of the latched burst
  // RESP  | presenting B until BREADY
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [2:0]          SIZE_MAX = 3'($clog2(DATA_BITS/8));
  localparam logic [LEN_BITS:0]   CNT_MAX  = '1;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

  logic [1:0]           state_q, state_d;
  logic [ID_BITS-1:0]   id_q, id_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [2:0]           size_q, size_d;
  logic [1:0]           burst_q, burst_d;
  logic [LEN_BITS:0]    cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic                 aw_hs, beat, b_hs, aw_err, wrap_len_ok, beyond_len;
  logic [LEN_BITS:0]    len_ext;
  logic [ADDR_BITS-1:0] step, wrap_len, wrap_mask, addr_incr, addr_nxt;

  // Outputs are gated by reset so they read idle while reset is held low.
  assign AWREADY = reset && (state_q == IDLE) && enable;
  assign WREADY  = reset && (state_q == DATA) && mem_ready;
  assign BVALID  = reset && (state_q == RESP);
  assign BID     = BVALID ? id_q : '0;
  assign BRESP   = (BVALID && err_q) ? 2'b10 : 2'b00;

  assign aw_hs = AWVALID && AWREADY;
  assign beat  = WVALID && WREADY;
  assign b_hs  = BVALID && BREADY;
  assign finish = b_hs;

  assign len_ext    = {1'b0, len_q};
  assign beyond_len = cnt_q > len_ext;

  assign mem_addr  = beat ? addr_q : '0;
  assign mem_wdata = beat ? WDATA : '0;
  assign mem_wen_n = (beat && !err_q && !beyond_len) ? ~WSTRB : '1;

  assign wrap_len_ok = (AWLEN == LEN_BITS'(1)) || (AWLEN == LEN_BITS'(3)) ||
                       (AWLEN == LEN_BITS'(7)) || (AWLEN == LEN_BITS'(15));
  assign aw_err = (AWSIZE > SIZE_MAX) || (AWBURST == BURST_RSVD) ||
                  ((AWBURST == BURST_WRAP) && !wrap_len_ok);

  // WRAP keeps the upper bits at the window base and wraps only the offset.
  assign step      = ADDR_ONE << size_q;
  assign wrap_len  = (ADDR_BITS'(len_q) + ADDR_ONE) << size_q;
  assign wrap_mask = wrap_len - ADDR_ONE;
  assign addr_incr = addr_q + step;

  always_comb begin
    addr_nxt = addr_q;
    case (burst_q)
      BURST_FIXED: addr_nxt = addr_q;
      BURST_INCR:  addr_nxt = addr_incr;
      BURST_WRAP:  addr_nxt = (addr_q & ~wrap_mask) | (addr_incr & wrap_mask);
      default:     addr_nxt = addr_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          id_d    = AWID;
          addr_d  = AWADDR;
          len_d   = AWLEN;
          size_d  = AWSIZE;
          burst_d = AWBURST;
          cnt_d   = '0;
          err_d   = aw_err;
          state_d = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          addr_d = addr_nxt;
          if (WLAST) begin
            state_d = RESP;
            if (cnt_q != len_ext) err_d = 1'b1;
          end else if (beyond_len) begin
            err_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (b_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_slave_write_burst.sv
// Directed bench for axi_slave_write_burst at DATA_BITS=32 with hand-computed
// addresses, enables and responses.
module tb_axi_slave_write_burst;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wen_n;
  logic [31:0] mem_wdata;
  logic        finish;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int fin_cnt  = 0;
  int wr_base;

  axi_slave_write_burst dut (
    .clock(clock), .reset(reset), .enable(enable),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wen_n(mem_wen_n),
    .mem_wdata(mem_wdata), .finish(finish)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset && mem_wen_n != 4'hF) wr_cnt++;
    if (finish) fin_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    #1 chk("aw_ready", AWREADY, 1'b1);
    tick();
    AWVALID = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last,
                      input logic [31:0] exp_addr, input logic [3:0] exp_wen);
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1; mem_ready = 1'b1;
    #1;
    chk("w_ready", WREADY, 1'b1);
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_wen_n", mem_wen_n, exp_wen);
    chk("mem_wdata", mem_wdata, (exp_wen == 4'hF) ? data : data);
    tick();
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic do_b(input logic [7:0] exp_id, input logic [1:0] exp_resp, input int hold);
    BREADY = 1'b0;
    for (int i = 0; i < hold; i++) begin
      #1;
      chk("b_hold_valid", BVALID, 1'b1);
      chk("b_hold_id", BID, exp_id);
      chk("b_hold_finish", finish, 1'b0);
      chk("b_hold_awready", AWREADY, 1'b0);
      tick();
    end
    BREADY = 1'b1;
    #1;
    chk("b_valid", BVALID, 1'b1);
    chk("b_id", BID, exp_id);
    chk("b_resp", BRESP, exp_resp);
    chk("b_finish", finish, 1'b1);
    chk("b_awready_same_cycle", AWREADY, 1'b0);
    tick();
    BREADY = 1'b0;
    #1;
    chk("b_valid_after", BVALID, 1'b0);
    chk("finish_after", finish, 1'b0);
    chk("awready_after_b", AWREADY, enable);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; AWVALID = 1'b0; AWID = '0; AWADDR = '0; AWLEN = '0;
    AWSIZE = '0; AWBURST = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
    BREADY = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    chk("rst_awready", AWREADY, 1'b0);
    chk("rst_wready", WREADY, 1'b0);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_wen_n", mem_wen_n, 4'hF);
    chk("rst_finish", finish, 1'b0);
    reset = 1'b1;
    tick();
    chk("idle_awready", AWREADY, 1'b1);

    // W presented while idle is refused
    WVALID = 1'b1; WDATA = 32'hDEAD; WSTRB = 4'hF;
    #1 chk("idle_wready", WREADY, 1'b0);
    chk("idle_wen_n", mem_wen_n, 4'hF);
    chk("idle_mem_addr", mem_addr, 32'h0);
    tick();
    WVALID = 1'b0;

    // INCR
    wr_base = wr_cnt;
    do_aw(8'h11, 32'h100, 4'd3, 3'd2, 2'b01);
    do_w(32'hA0, 4'hF, 1'b0, 32'h100, 4'h0);
    do_w(32'hA1, 4'hF, 1'b0, 32'h104, 4'h0);
    do_w(32'hA2, 4'hF, 1'b0, 32'h108, 4'h0);
    do_w(32'hA3, 4'hF, 1'b1, 32'h10C, 4'h0);
    do_b(8'h11, 2'b00, 0);
    chk("incr_writes", wr_cnt - wr_base, 4);
    chk("incr_finish_cnt", fin_cnt, 1);

    // WRAP
    do_aw(8'h22, 32'h38, 4'd3, 3'd2, 2'b10);
    do_w(32'hB0, 4'h3, 1'b0, 32'h38, 4'hC);
    do_w(32'hB1, 4'hF, 1'b0, 32'h3C, 4'h0);
    do_w(32'hB2, 4'hF, 1'b0, 32'h30, 4'h0);
    do_w(32'hB3, 4'h8, 1'b1, 32'h34, 4'h7);
    do_b(8'h22, 2'b00, 0);

    // FIXED with a mem_ready stall on the second cycle
    wr_base = wr_cnt;
    do_aw(8'h33, 32'h40, 4'd2, 3'd2, 2'b00);
    do_w(32'hC0, 4'hF, 1'b0, 32'h40, 4'h0);
    mem_ready = 1'b0; WVALID = 1'b1; WDATA = 32'hC1;
    #1 chk("stall_wready", WREADY, 1'b0);
    chk("stall_wen_n", mem_wen_n, 4'hF);
    chk("stall_addr", mem_addr, 32'h0);
    tick();
    WVALID = 1'b0;
    do_w(32'hC1, 4'hF, 1'b0, 32'h40, 4'h0);
    do_w(32'hC2, 4'hF, 1'b1, 32'h40, 4'h0);
    do_b(8'h33, 2'b00, 0);
    chk("fixed_writes", wr_cnt - wr_base, 3);

    // oversize AWSIZE: beats accepted, nothing written
    wr_base = wr_cnt;
    do_aw(8'h44, 32'h200, 4'd1, 3'd3, 2'b01);
    do_w(32'hD0, 4'hF, 1'b0, 32'h200, 4'hF);
    do_w(32'hD1, 4'hF, 1'b1, 32'h208, 4'hF);
    do_b(8'h44, 2'b10, 0);
    chk("size_err_writes", wr_cnt - wr_base, 0);

    // early WLAST on beat 1 of LEN=3
    do_aw(8'h45, 32'h300, 4'd3, 3'd2, 2'b01);
    do_w(32'hE0, 4'hF, 1'b0, 32'h300, 4'h0);
    do_w(32'hE1, 4'hF, 1'b1, 32'h304, 4'h0);
    do_b(8'h45, 2'b10, 0);

    // beat beyond LEN=1 without WLAST; enable dropped mid-burst
    wr_base = wr_cnt;
    do_aw(8'h46, 32'h400, 4'd1, 3'd2, 2'b01);
    enable = 1'b0;
    do_w(32'hF0, 4'hF, 1'b0, 32'h400, 4'h0);
    do_w(32'hF1, 4'hF, 1'b0, 32'h404, 4'h0);
    do_w(32'hF2, 4'hF, 1'b1, 32'h408, 4'hF);
    enable = 1'b1;
    do_b(8'h46, 2'b10, 0);
    chk("beyond_writes", wr_cnt - wr_base, 2);

    // reset after beat 1 of LEN=3
    do_aw(8'h47, 32'h500, 4'd3, 3'd2, 2'b01);
    do_w(32'h10, 4'hF, 1'b0, 32'h500, 4'h0);
    reset = 1'b0;
    #1 chk("midrst_wready", WREADY, 1'b0);
    chk("midrst_awready", AWREADY, 1'b0);
    tick();
    reset = 1'b1;
    #1 chk("postrst_awready", AWREADY, 1'b1);
    chk("postrst_bvalid", BVALID, 1'b0);
    enable = 1'b0;
    #1 chk("postrst_awready_dis", AWREADY, 1'b0);
    enable = 1'b1;
    do_aw(8'h5A, 32'h600, 4'd0, 3'd2, 2'b01);
    do_w(32'h20, 4'hF, 1'b1, 32'h600, 4'h0);
    do_b(8'h5A, 2'b00, 0);

    // BREADY held low 5 cycles; new AW waiting during the handshake
    do_aw(8'h77, 32'h700, 4'd0, 3'd2, 2'b01);
    do_w(32'h30, 4'hF, 1'b1, 32'h700, 4'h0);
    AWID = 8'h78; AWADDR = 32'h800; AWLEN = 4'd0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    do_b(8'h77, 2'b00, 5);
    tick();
    AWVALID = 1'b0;
    do_w(32'h40, 4'hF, 1'b1, 32'h800, 4'h0);
    do_b(8'h78, 2'b00, 0);
    chk("total_finish", fin_cnt, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
